safe_input_arbiter: RTL and testbench
=====================================

SAFE_INPUT_ARBITER -- requirements
Module: safe_input_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 2, number of input requesters (keypad, service port, door sensor ...); range 2..8.
REQ-002 Parameter SESSION_TIMEOUT, default 2000, idle cycles after which an owned session is released.
REQ-003 clk_i  in  1  clock, rising edge.
REQ-004 arst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 src_data_i  in  NUM_SRC x data_in (safe_pkg)  per-source key/event code.
REQ-006 src_valid_i / src_ready_o  in / out  NUM_SRC each  per-source input handshake.
REQ-007 safe_data_o / safe_valid_o / safe_ready_i  out / out / in  data_in, 1, 1  stream to the safe input port.
REQ-008 safe_rsp_i / safe_rsp_valid_i / safe_rsp_ready_o  in / in / out  data_out, 1, 1  response stream from the safe.
REQ-009 src_rsp_o / src_rsp_valid_o / src_rsp_ready_i  out / out / in  data_out, NUM_SRC, NUM_SRC  response routed to sources; src_rsp_o shared by all.
REQ-010 owner_o / owned_o  out  max(1,ceil(log2 NUM_SRC)), 1  current owner index and session-active flag.

Function
REQ-011 FSM states IDLE, OWNED; owner index and round-robin pointer are registers.
REQ-012 IDLE: all src_ready_o = 0, safe_valid_o = 0; if any src_valid_i, grant first valid source at or after pointer (wrapping NUM_SRC-1 -> 0), register owner, go OWNED next cycle.
REQ-013 Grant latency: first owner beat reaches the safe exactly 1 cycle after src_valid_i first sampled high in IDLE.
REQ-014 OWNED: combinational pass-through: safe_data_o = src_data_i[owner], safe_valid_o = src_valid_i[owner], src_ready_o[owner] = safe_ready_i; all non-owner src_ready_o = 0.
REQ-015 Non-owner valid beats are held off (not dropped); sources keep data stable until ready.
REQ-016 Idle counter, width ceil(log2(SESSION_TIMEOUT+1)): cleared on IDLE, on every forwarded handshake, and on every owner src_valid_i high cycle (covers held KEY_CLEAR long press); else increments, saturating at SESSION_TIMEOUT.
REQ-017 OWNED -> IDLE when counter reaches SESSION_TIMEOUT, or when a safe response handshake completes while OWNED.
REQ-018 On release, pointer := owner + 1 mod NUM_SRC; next grant evaluated the cycle after release (one mandatory IDLE cycle).
REQ-019 Response while OWNED: src_rsp_valid_o[owner] = safe_rsp_valid_i, safe_rsp_ready_o = src_rsp_ready_i[owner], other valid bits 0; src_rsp_o = safe_rsp_i.
REQ-020 Response handshake and idle timeout in the same cycle: response is delivered to owner, single release.
REQ-021 Owner beat handshake and response handshake in same cycle: beat is forwarded, session released afterwards.
REQ-022 Response while IDLE (unowned, e.g. BLOCK, TIMEOUT) handled per REQ-027/028.
REQ-023 Response stream is never reordered or buffered; zero storage on either path.

Reset
REQ-024 arst_n_i low: state IDLE, owner 0, pointer 0, counter 0 immediately (asynchronous).
REQ-025 During reset: all src_ready_o 0, safe_valid_o 0, safe_rsp_ready_o 0, all src_rsp_valid_o 0, owned_o 0, owner_o 0.
REQ-026 Reset mid-session aborts the session with no beat forwarded after the asserting edge; first grant possible one cycle after release of reset.

Configuration
REQ-027 Macro SAFE_ARB_RSP_BROADCAST_EN defined: unowned response asserts every src_rsp_valid_o bit; safe_rsp_ready_o = AND of all src_rsp_ready_i; held until all ready simultaneously.
REQ-028 Macro undefined: unowned response consumed and discarded (safe_rsp_ready_o = 1 while IDLE, all src_rsp_valid_o 0).

Verification
REQ-029 NUM_SRC=2, src 0 sends KEY_1,KEY_2,KEY_3,KEY_4,KEY_OK, src 1 valid throughout -> src 1 ready stays 0; safe sees exactly the 5 src-0 codes in order; PASS_OK routed only to src_rsp_valid_o[0]; src 1 granted the cycle after next.
REQ-030 Both sources valid in IDLE after reset -> src 0 granted; after release both valid again -> src 1 granted (round-robin).
REQ-031 SESSION_TIMEOUT=16, owner sends KEY_5 then idles -> owned_o falls exactly 16 cycles after last handshake; held KEY_CLEAR for 100 cycles keeps session owned.
REQ-032 Safe returns TIMEOUT in the same cycle the idle counter saturates -> src_rsp_valid_o[owner]=1, one release, pointer advanced once.
REQ-033 Unowned BLOCK response, src_rsp_ready_i = 01 then 11 -> with macro: completes only on 11, both valid bits high; without macro: consumed in 1 cycle, no valid bits.
REQ-034 Assert arst_n_i low mid-session after KEY_2 -> outputs per REQ-025 same cycle; after release, no further owner beats forwarded until regrant.

Source files
------------

// File: rtl/safe_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : safe_input_arbiter (plus safe_pkg key/response code definitions)
// Function : round-robin session arbiter from NUM_SRC input sources to a safe.
//            Macro SAFE_ARB_RSP_BROADCAST_EN broadcasts unowned safe responses.
// Revision : 1.0 - initial release
// ============================================================================
package safe_pkg;
  typedef logic [7:0] data_in;
  typedef logic [7:0] data_out;

  localparam data_in KEY_0     = 8'h30;
  localparam data_in KEY_1     = 8'h31;
  localparam data_in KEY_2     = 8'h32;
  localparam data_in KEY_3     = 8'h33;
  localparam data_in KEY_4     = 8'h34;
  localparam data_in KEY_5     = 8'h35;
  localparam data_in KEY_6     = 8'h36;
  localparam data_in KEY_7     = 8'h37;
  localparam data_in KEY_8     = 8'h38;
  localparam data_in KEY_9     = 8'h39;
  localparam data_in KEY_OK    = 8'h0D;
  localparam data_in KEY_CLEAR = 8'h08;

  localparam data_out PASS_OK   = 8'hA0;
  localparam data_out PASS_FAIL = 8'hA1;
  localparam data_out BLOCK     = 8'hB0;
  localparam data_out TIMEOUT   = 8'hC0;
endpackage

module safe_input_arbiter #(
  parameter int NUM_SRC         = 2,
  parameter int SESSION_TIMEOUT = 2000,
  localparam int OWN_W          = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                           clk_i,
  input  logic                           arst_n_i,
  input  safe_pkg::data_in [NUM_SRC-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]             src_valid_i,
  output logic [NUM_SRC-1:0]             src_ready_o,
  output safe_pkg::data_in               safe_data_o,
  output logic                           safe_valid_o,
  input  logic                           safe_ready_i,
  input  safe_pkg::data_out              safe_rsp_i,
  input  logic                           safe_rsp_valid_i,
  output logic                           safe_rsp_ready_o,
  output safe_pkg::data_out              src_rsp_o,
  output logic [NUM_SRC-1:0]             src_rsp_valid_o,
  input  logic [NUM_SRC-1:0]             src_rsp_ready_i,
  output logic [OWN_W-1:0]               owner_o,
  output logic                           owned_o
);

  localparam int CNT_W = (SESSION_TIMEOUT > 0) ? $clog2(SESSION_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(SESSION_TIMEOUT);
  localparam logic [OWN_W-1:0] c_LAST    = OWN_W'(NUM_SRC - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [OWN_W-1:0] r_owner, w_owner_nxt;
  logic [OWN_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [OWN_W-1:0] w_grant;
  logic [OWN_W-1:0] w_cand;
  logic             w_found;
  logic             w_fwd;
  logic             w_rsp_hs;
  logic [CNT_W-1:0] w_cnt_run;

  // First valid source at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_cand = OWN_W'((int'(r_ptr) + i) % NUM_SRC);
      if (!w_found && src_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_ptr_nxt        = r_ptr;
    w_cnt_nxt        = '0;
    w_cnt_run        = '0;
    w_fwd            = 1'b0;
    w_rsp_hs         = 1'b0;
    src_ready_o      = '0;
    safe_valid_o     = 1'b0;
    safe_data_o      = src_data_i[r_owner];
    src_rsp_o        = safe_rsp_i;
    src_rsp_valid_o  = '0;
    safe_rsp_ready_o = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_OWNED;
          w_owner_nxt = w_grant;
        end
        // Unowned responses; reset gating keeps ready/valid low while in reset.
`ifdef SAFE_ARB_RSP_BROADCAST_EN
        src_rsp_valid_o  = {NUM_SRC{safe_rsp_valid_i & arst_n_i}};
        safe_rsp_ready_o = (&src_rsp_ready_i) & arst_n_i;
`else
        safe_rsp_ready_o = arst_n_i;
`endif
      end

      S_OWNED: begin
        safe_valid_o             = src_valid_i[r_owner];
        src_ready_o[r_owner]     = safe_ready_i;
        src_rsp_valid_o[r_owner] = safe_rsp_valid_i;
        safe_rsp_ready_o         = src_rsp_ready_i[r_owner];
        w_fwd    = src_valid_i[r_owner] & safe_ready_i;
        w_rsp_hs = safe_rsp_valid_i & src_rsp_ready_i[r_owner];

        // A held key keeps the session alive even while the safe stalls it.
        if (w_fwd || src_valid_i[r_owner])
          w_cnt_run = '0;
        else if (r_cnt == c_TIMEOUT)
          w_cnt_run = r_cnt;
        else
          w_cnt_run = r_cnt + CNT_W'(1);

        if (w_rsp_hs || (w_cnt_run == c_TIMEOUT)) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = (r_owner == c_LAST) ? '0 : r_owner + OWN_W'(1);
        end else begin
          w_cnt_nxt = w_cnt_run;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign owner_o = r_owner;
  assign owned_o = (r_state == S_OWNED);

endmodule
`default_nettype wire

// File: tb/tb_safe_input_arbiter.sv
`default_nettype none
// Testbench for safe_input_arbiter: scoreboard of expected safe-side beats plus
// directed checks on arbitration, timeout, response routing and reset.
module tb_safe_input_arbiter;
  import safe_pkg::*;

  localparam int NSRC = 2;
  localparam int TMO  = 16;

  logic                  clk = 1'b0;
  logic                  arst_n;
  data_in [NSRC-1:0]     src_data;
  logic   [NSRC-1:0]     src_valid;
  logic   [NSRC-1:0]     src_ready;
  data_in                safe_data;
  logic                  safe_valid;
  logic                  safe_ready;
  data_out               safe_rsp;
  logic                  safe_rsp_valid;
  logic                  safe_rsp_ready;
  data_out               src_rsp;
  logic   [NSRC-1:0]     src_rsp_valid;
  logic   [NSRC-1:0]     src_rsp_ready;
  logic   [0:0]          owner;
  logic                  owned;

  typedef struct packed {
    logic [0:0] src;
    data_in     code;
  } beat_t;

  beat_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  safe_input_arbiter #(
    .NUM_SRC         (NSRC),
    .SESSION_TIMEOUT (TMO)
  ) dut (
    .clk_i            (clk),
    .arst_n_i         (arst_n),
    .src_data_i       (src_data),
    .src_valid_i      (src_valid),
    .src_ready_o      (src_ready),
    .safe_data_o      (safe_data),
    .safe_valid_o     (safe_valid),
    .safe_ready_i     (safe_ready),
    .safe_rsp_i       (safe_rsp),
    .safe_rsp_valid_i (safe_rsp_valid),
    .safe_rsp_ready_o (safe_rsp_ready),
    .src_rsp_o        (src_rsp),
    .src_rsp_valid_o  (src_rsp_valid),
    .src_rsp_ready_i  (src_rsp_ready),
    .owner_o          (owner),
    .owned_o          (owned)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Safe-side monitor: every forwarded beat must match the next expected one.
  always @(negedge clk) begin
    beat_t exp_b;
    check("src_ready", 32'(src_ready), owned ? 32'(2'(safe_ready) << owner) : 32'd0);
    if (safe_valid && safe_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_beat", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_b = sb_q.pop_front();
        check("safe_data", 32'(safe_data), 32'(exp_b.code));
        check("safe_src", 32'(owner), 32'(exp_b.src));
      end
    end
  end

  task automatic expect_beat(input logic [0:0] s, input data_in c);
    beat_t b;
    b.src  = s;
    b.code = c;
    sb_q.push_back(b);
  endtask

  task automatic wait_hs(input int s, output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      waits++;
      if (src_valid[s] && src_ready[s]) got = 1'b1;
    end
    check("hs_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    src_valid[s] = 1'b0;
  endtask

  task automatic send(input int s, input data_in c, output int waits);
    src_data[s]  = c;
    src_valid[s] = 1'b1;
    wait_hs(s, waits);
  endtask

  task automatic rsp(input data_out code, input logic [1:0] rdy, output logic [1:0] seen);
    bit got;
    got            = 1'b0;
    seen           = '0;
    safe_rsp       = code;
    safe_rsp_valid = 1'b1;
    src_rsp_ready  = rdy;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (safe_rsp_ready) begin
        got  = 1'b1;
        seen = src_rsp_valid;
        check("rsp_data", 32'(src_rsp), 32'(code));
      end
    end
    check("rsp_hs_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    safe_rsp_valid = 1'b0;
    src_rsp_ready  = '0;
  endtask

  task automatic measure_owned(output int n);
    bit done;
    done = 1'b0;
    n    = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (owned) n++;
      else done = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int         w;
    int         n;
    logic [1:0] seen;

    // Reset with every input pushing for activity.
    arst_n         = 1'b1;
    src_data       = '0;
    src_valid      = '1;
    safe_ready     = 1'b1;
    safe_rsp       = BLOCK;
    safe_rsp_valid = 1'b1;
    src_rsp_ready  = '1;
    #1 arst_n = 1'b0;
    #1;
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_safe_valid", 32'(safe_valid), 32'd0);
    check("rst_rsp_ready", 32'(safe_rsp_ready), 32'd0);
    check("rst_rsp_valid", 32'(src_rsp_valid), 32'd0);
    check("rst_owned", 32'(owned), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    repeat (3) @(posedge clk); #1;
    src_valid      = '0;
    safe_rsp_valid = 1'b0;
    src_rsp_ready  = '0;
    arst_n         = 1'b1;
    @(posedge clk); #1;

    // Src 0 session while src 1 waits; src 0 wins the first grant.
    expect_beat(0, KEY_1); expect_beat(0, KEY_2); expect_beat(0, KEY_3);
    expect_beat(0, KEY_4); expect_beat(0, KEY_OK); expect_beat(1, KEY_9);
    src_data[1]  = KEY_9;
    src_valid[1] = 1'b1;
    send(0, KEY_1, w);
    check("grant_latency", 32'(w), 32'd2);
    send(0, KEY_2, w);
    send(0, KEY_3, w);
    send(0, KEY_4, w);
    send(0, KEY_OK, w);
    rsp(PASS_OK, 2'b11, seen);
    check("pass_ok_route", 32'(seen), 32'b01);
    wait_hs(1, w);
    check("rr_regrant_latency", 32'(w), 32'd2);

    // Idle timeout after last handshake.
    measure_owned(n);
    check("timeout_src1", 32'(n), 32'(TMO));
    expect_beat(0, KEY_5);
    send(0, KEY_5, w);
    measure_owned(n);
    check("timeout_key5", 32'(n), 32'(TMO));

    // Held KEY_CLEAR stalled by the safe keeps the session.
    safe_ready = 1'b0;
    expect_beat(0, KEY_CLEAR);
    src_data[0]  = KEY_CLEAR;
    src_valid[0] = 1'b1;
    w = 0;
    while (!owned && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("hold_grant", 32'(owned), 32'd1);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (owned) n++;
    end
    check("hold_owned", 32'(n), 32'd100);
    @(posedge clk); #1;
    safe_ready = 1'b1;
    wait_hs(0, w);

    // TIMEOUT response in the cycle the idle count expires.
    repeat (TMO - 1) @(posedge clk);
    #1;
    safe_rsp       = TIMEOUT;
    safe_rsp_valid = 1'b1;
    src_rsp_ready  = 2'b11;
    @(negedge clk);
    check("tmo_rsp_valid", 32'(src_rsp_valid), 32'b01);
    check("tmo_rsp_ready", 32'(safe_rsp_ready), 32'd1);
    check("tmo_still_owned", 32'(owned), 32'd1);
    @(posedge clk); #1;
    safe_rsp_valid = 1'b0;
    src_rsp_ready  = '0;
    expect_beat(1, KEY_3);
    expect_beat(0, KEY_2);
    src_data[0] = KEY_2;
    src_data[1] = KEY_3;
    src_valid   = 2'b11;
    wait_hs(1, w);
    check("tmo_single_release", 32'(w), 32'd2);
    rsp(PASS_OK, 2'b11, seen);
    check("rsp_src1_route", 32'(seen), 32'b10);
    wait_hs(0, w);

    // Owner beat and response handshake in the same cycle.
    expect_beat(0, KEY_4);
    src_data[0]    = KEY_4;
    src_valid[0]   = 1'b1;
    safe_rsp       = PASS_FAIL;
    safe_rsp_valid = 1'b1;
    src_rsp_ready  = 2'b11;
    @(negedge clk);
    check("dual_safe_valid", 32'(safe_valid), 32'd1);
    check("dual_rsp_valid", 32'(src_rsp_valid), 32'b01);
    check("dual_rsp_ready", 32'(safe_rsp_ready), 32'd1);
    @(posedge clk); #1;
    src_valid[0]   = 1'b0;
    safe_rsp_valid = 1'b0;
    src_rsp_ready  = '0;
    @(negedge clk);
    check("dual_released", 32'(owned), 32'd0);

    // Unowned BLOCK response.
    @(posedge clk); #1;
    safe_rsp       = BLOCK;
    safe_rsp_valid = 1'b1;
    src_rsp_ready  = 2'b01;
    @(negedge clk);
    check("block_data", 32'(src_rsp), 32'(BLOCK));
`ifdef SAFE_ARB_RSP_BROADCAST_EN
    check("block_valid_01", 32'(src_rsp_valid), 32'b11);
    check("block_ready_01", 32'(safe_rsp_ready), 32'd0);
    @(posedge clk); #1;
    src_rsp_ready = 2'b11;
    @(negedge clk);
    check("block_valid_11", 32'(src_rsp_valid), 32'b11);
    check("block_ready_11", 32'(safe_rsp_ready), 32'd1);
`else
    check("block_valid_01", 32'(src_rsp_valid), 32'b00);
    check("block_ready_01", 32'(safe_rsp_ready), 32'd1);
`endif
    @(posedge clk); #1;
    safe_rsp_valid = 1'b0;
    src_rsp_ready  = '0;

    // Reset in the middle of a src 1 session.
    expect_beat(1, KEY_1);
    expect_beat(1, KEY_2);
    send(1, KEY_1, w);
    send(1, KEY_2, w);
    src_data[1]    = KEY_8;
    src_valid[1]   = 1'b1;
    safe_rsp       = BLOCK;
    safe_rsp_valid = 1'b1;
    src_rsp_ready  = 2'b11;
    arst_n         = 1'b0;
    #1;
    check("mid_rst_safe_valid", 32'(safe_valid), 32'd0);
    check("mid_rst_src_ready", 32'(src_ready), 32'd0);
    check("mid_rst_owned", 32'(owned), 32'd0);
    check("mid_rst_owner", 32'(owner), 32'd0);
    check("mid_rst_rsp_ready", 32'(safe_rsp_ready), 32'd0);
    check("mid_rst_rsp_valid", 32'(src_rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    safe_rsp_valid = 1'b0;
    src_rsp_ready  = '0;
    src_data[0]    = KEY_3;
    src_valid[0]   = 1'b1;
    arst_n         = 1'b1;
    expect_beat(0, KEY_3);
    expect_beat(1, KEY_8);
    wait_hs(0, w);
    check("post_rst_latency", 32'(w), 32'd2);
    rsp(PASS_OK, 2'b11, seen);
    check("post_rst_route", 32'(seen), 32'b01);
    wait_hs(1, w);
    measure_owned(n);
    check("post_rst_timeout", 32'(n), 32'(TMO));

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
